// File: rtl/cpu_issue_sequencer.sv
// cpu_issue_sequencer: FIFO-buffered command sequencer that drives the cpu datapath and captures its result
module cpu_issue_sequencer #(
    parameter int DEPTH = 8,
    parameter int CMD_W = 52
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CMD_W-1:0]         cmd_in,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [4:0]               addressA,
    output logic [4:0]               addressB,
    output logic [31:0]              dataIn,
    output logic [1:0]               opsel,
    output logic [1:0]               outsel,
    output logic                     asel,
    output logic                     bsel,
    output logic                     oen,
    input  logic [31:0]              cpu_out,
    input  logic                     cpu_over,
    output logic [31:0]              res_data,
    output logic                     res_over,
    output logic                     res_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    // oen=0, bsel=1, asel=1, everything else zero
    localparam logic [48:0] NOP = {1'b0, 1'b1, 1'b1, 46'd0};

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t           r_state;
    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic [48:0]      r_issue;
    logic [2:0]       r_cnt;
    logic [31:0]      r_res_data;
    logic             r_res_over;
    logic             r_res_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic [CMD_W-1:0] w_head;

    assign cmd_ready = r_level != FULL;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_last    = (r_state == ISSUE) && (r_cnt == 3'd0);
    // registered level means a same-cycle push into an empty FIFO is never popped
    assign w_pop     = (r_level != '0) && ((r_state == IDLE) || w_last);
    assign w_head    = r_mem[r_rptr];
    assign {oen, bsel, asel, outsel, opsel, addressB, addressA, dataIn} = r_issue;
    assign res_data  = r_res_data;
    assign res_over  = r_res_over;
    assign res_valid = r_res_valid;
    assign busy      = (r_state == ISSUE) || (r_level != '0);
    assign level     = r_level;

    // command storage, no reset needed since level gates every read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= cmd_in;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
            r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // issue FSM: hold each command for hold+1 cycles, then capture the cpu result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_issue     <= NOP;
            r_cnt       <= '0;
            r_res_data  <= '0;
            r_res_over  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= w_last && r_issue[48];
            if (w_last && r_issue[48]) begin
                r_res_data <= cpu_out;
                r_res_over <= cpu_over;
            end
            if (w_pop) begin
                r_state <= ISSUE;
                r_issue <= w_head[48:0];
                r_cnt   <= w_head[51:49];
            end else if (w_last) begin
                r_state <= IDLE;
                r_issue <= NOP;
            end else if (r_state == ISSUE) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_cpu_issue_sequencer.sv
// tb_cpu_issue_sequencer: randomized bench against a timeline model of command acceptance and issue
module tb_cpu_issue_sequencer;
    localparam logic [48:0] NOP = {1'b0, 1'b1, 1'b1, 46'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [51:0] cmd_in = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  addressA, addressB;
    logic [31:0] dataIn;
    logic [1:0]  opsel, outsel;
    logic        asel, bsel, oen;
    logic [31:0] cpu_out = '0;
    logic        cpu_over = 1'b0;
    logic [31:0] res_data;
    logic        res_over, res_valid, busy;
    logic [3:0]  level;
    logic [48:0] ctl;

    always #5 clk = ~clk;

    assign ctl = {oen, bsel, asel, outsel, opsel, addressB, addressA, dataIn};

    cpu_issue_sequencer dut (
        .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .addressA(addressA), .addressB(addressB), .dataIn(dataIn), .opsel(opsel), .outsel(outsel),
        .asel(asel), .bsel(bsel), .oen(oen), .cpu_out(cpu_out), .cpu_over(cpu_over),
        .res_data(res_data), .res_over(res_over), .res_valid(res_valid), .busy(busy), .level(level)
    );

    // model: every accepted command with its acceptance edge and its issue start edge
    logic [51:0] q_cmd[$];
    int          q_acc[$];
    int          q_st[$];
    logic [32:0] hist[int];
    int          t = 0;
    int          last_end = 0;
    bit          m_ready = 1'b1;
    bit          m_acc = 1'b0;
    bit          m_busy = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          mx_dut = 0;
    int          mx_exp = 0;
    int          n_strb = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [51:0] mk(int h, bit oe, bit bs, bit as, logic [1:0] os, logic [1:0] op,
                                       logic [4:0] b, logic [4:0] a, logic [31:0] d);
        return {3'(h), oe, bs, as, os, op, b, a, d};
    endfunction

    // one clock: advance the model, then compare every output against it
    task automatic step();
        int lvl;
        bit act;
        bit e_rv;
        logic [48:0] e_out;
        logic [32:0] e_res;
        @(posedge clk);
        m_acc = 1'b0;
        if (rst) begin
            q_cmd.delete(); q_acc.delete(); q_st.delete(); hist.delete();
            t = 0;
            last_end = 0;
        end else begin
            t++;
            hist[t] = {cpu_over, cpu_out};
            if (cmd_valid && m_ready) begin
                int s;
                s = (t + 1 > last_end) ? t + 1 : last_end;
                q_cmd.push_back(cmd_in); q_acc.push_back(t); q_st.push_back(s);
                last_end = s + int'(cmd_in[51:49]) + 1;
                m_acc = 1'b1;
            end
        end
        #1;
        lvl = 0; act = 1'b0; e_rv = 1'b0; e_out = NOP; e_res = '0;
        foreach (q_cmd[i]) begin
            int e;
            e = q_st[i] + int'(q_cmd[i][51:49]) + 1;
            if (q_acc[i] <= t) lvl++;
            if (q_st[i] <= t) lvl--;
            if (q_st[i] <= t && t < e) begin act = 1'b1; e_out = q_cmd[i][48:0]; end
            if (e <= t && q_cmd[i][48]) e_res = hist[e];
            if (e == t && q_cmd[i][48]) e_rv = 1'b1;
        end
        m_ready = (lvl != 8);
        m_busy = act || (lvl != 0);
        chk("level", 64'(level), 64'(lvl));
        chk("cmd_ready", 64'(cmd_ready), 64'(m_ready));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("cpu_ctl", 64'(ctl), 64'(e_out));
        chk("res_valid", 64'(res_valid), 64'(e_rv));
        chk("result", 64'({res_over, res_data}), 64'(e_res));
        if (int'(level) > mx_dut) mx_dut = int'(level);
        if (lvl > mx_exp) mx_exp = lvl;
        n_strb += int'(res_valid);
        cpu_out = $urandom;
        cpu_over = 1'($urandom_range(0, 1));
    endtask

    task automatic push(logic [51:0] c);
        int n;
        n = 0;
        cmd_in = c;
        cmd_valid = 1'b1;
        do begin step(); n++; end while (!m_acc && n < 200);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_busy && n < 500) begin step(); n++; end
        step();
    endtask

    initial begin
        logic [63:0] r;
        logic [51:0] c;
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_ctl", 64'(ctl), 64'(NOP));
        chk("rst_ready", 64'(cmd_ready), 64'(1));
        // stores: four back-to-back pushes, hold=1
        mx_dut = 0; mx_exp = 0; n_strb = 0;
        push(mk(1, 1, 0, 0, 2'b00, 2'b01, 5'd0, 5'd0, 32'hFFFF_FFEF));
        push(mk(1, 1, 0, 0, 2'b00, 2'b01, 5'd0, 5'd1, 32'h0000_0011));
        push(mk(1, 1, 0, 0, 2'b00, 2'b01, 5'd0, 5'd2, 32'h0000_0022));
        push(mk(1, 1, 0, 0, 2'b00, 2'b01, 5'd0, 5'd22, 32'h0000_0044));
        drain();
        chk("store_peak", 64'(mx_dut), 64'(mx_exp));
        chk("store_strobes", 64'(n_strb), 64'(4));
        chk("store_busy_end", 64'(busy), 64'(0));
        // ALU-style commands, hold=3
        push(mk(3, 1, 1, 1, 2'b01, 2'b00, 5'd1, 5'd0, 32'd0));
        push(mk(3, 1, 1, 1, 2'b01, 2'b01, 5'd22, 5'd0, 32'd0));
        push(mk(3, 1, 1, 1, 2'b10, 2'b00, 5'd0, 5'd2, 32'd0));
        drain();
        // full FIFO behind a hold=7 command
        push(mk(7, 1, 0, 1, 2'b01, 2'b10, 5'd3, 5'd4, 32'hA5A5_0001));
        step();
        for (int i = 0; i < 9; i++) push(mk(i % 3, 1, 1, 0, 2'b11, 2'b01, 5'(i), 5'(i + 1), 32'h1000 + i));
        drain();
        // suppressed strobe
        n_strb = 0;
        push(mk(2, 0, 1, 1, 2'b01, 2'b11, 5'd7, 5'd9, 32'hDEAD_BEEF));
        drain();
        chk("oen0_no_strobe", 64'(n_strb), 64'(0));
        // reset while issuing with level 5
        push(mk(7, 1, 0, 0, 2'b00, 2'b01, 5'd1, 5'd1, 32'h1234_5678));
        for (int i = 0; i < 5; i++) push(mk(1, 1, 0, 0, 2'b00, 2'b01, 5'd2, 5'(i), 32'h55 + i));
        chk("pre_rst_level", 64'(level), 64'(5));
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_level", 64'(level), 64'(0));
        chk("mid_rst_ctl", 64'(ctl), 64'(NOP));
        chk("mid_rst_ready", 64'(cmd_ready), 64'(1));
        n_strb = 0;
        repeat (20) step();
        chk("no_late_strobe", 64'(n_strb), 64'(0));
        // single push into an empty FIFO: no bypass
        c = mk(0, 1, 0, 1, 2'b10, 2'b11, 5'd30, 5'd31, 32'hCAFE_F00D);
        push(c);
        chk("empty_push_nop", 64'(ctl), 64'(NOP));
        step();
        chk("empty_push_issue", 64'(ctl), 64'(c[48:0]));
        drain();
        // randomized traffic with sparse resets
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 400; i++) begin
                r = {$urandom, $urandom};
                cmd_in = r[51:0];
                cmd_valid = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                rst = ($urandom_range(0, 149) == 0);
                step();
            end
            rst = 1'b0;
            cmd_valid = 1'b0;
            drain();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
